// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first,
// one bit per clock, running borrow held in a flop.
// Ports: clk, rst_n (async, active-low), start/a/b/bin (request and
// operands, captured in IDLE), busy/done (handshake), diff/bout (result),
// zero (result==0, only when SERIAL_SUB_ZERO_FLAG_EN is defined).
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_sh_q;
    logic             brw_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;

    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             brw_d;
    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-1:0] r_sh_d;

    // Full-subtractor cell
    assign a0     = a_sh_q[0];
    assign b0     = b_sh_q[0];
    assign d_bit  = a0 ^ b0 ^ brw_q;
    assign brw_d  = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
    assign a_sh_d = a_sh_q >> 1;
    assign b_sh_d = b_sh_q >> 1;

    // New difference bit enters at the MSB; after WIDTH shifts the
    // register holds the result in natural bit order.
    generate
        if (WIDTH == 1) begin : g_r1
            assign r_sh_d = d_bit;
        end else begin : g_rn
            assign r_sh_d = {d_bit, r_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_d;
                    b_sh_q <= b_sh_d;
                    r_sh_q <= r_sh_d;
                    brw_q  <= brw_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        diff_q  <= r_sh_d;
                        bout_q  <= brw_d;
                        zero_q  <= (r_sh_d == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign zero = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8 and WIDTH=1).
// Transaction-level model plus directed literal checks.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    logic start1 = 1'b0;
    logic a1 = 1'b0;
    logic b1 = 1'b0;
    logic bin1 = 1'b0;
    logic busy1, done1, bout1;
    logic diff1;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic zero, zero1;
`endif

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        , .zero(zero1)
`endif
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: t = -1 when ready, otherwise cycles since the accepted start.
    // Result published W cycles after acceptance; ready again 2 later.
    int           t = -1;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic         m_zero = 1'b0;
    logic [W-1:0] p_diff;
    logic         p_bout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t      = -1;
            m_diff = '0;
            m_bout = 1'b0;
            m_zero = 1'b0;
        end else if (t < 0) begin
            if (start) begin
                int unsigned ia, ib, ic;
                ia = a;
                ib = b;
                ic = bin;
                p_diff = W'((ia + 256 - ib - ic) % 256);
                p_bout = (ia < ib + ic);
                t = 0;
            end
        end else if (t == W) begin
            t = -1;
        end else begin
            t++;
            if (t == W) begin
                m_diff = p_diff;
                m_bout = p_bout;
                m_zero = (p_diff == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (t >= 0 && t < W));
            chk("done", done, (t == W));
            chk("diff", diff, m_diff);
            chk("bout", bout, m_bout);
            chk("busy_done_excl", busy & done, 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            chk("zero", zero, m_zero);
`endif
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (t >= 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (t >= 0) begin
            fails++;
            $display("FAIL wait_idle: got busy expected idle");
        end
    endtask

    task automatic run_op(input string nm, input logic [7:0] ia,
                          input logic [7:0] ib, input logic ic,
                          input logic [7:0] ed, input logic eb,
                          input logic ez);
        int lat = 0;
        wait_idle();
        a = ia;
        b = ib;
        bin = ic;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        bin = $urandom;
        while (!done && lat < 15) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, 8);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_bout"}, bout, eb);
        chk({nm, "_model_diff"}, m_diff, ed);
        chk({nm, "_model_bout"}, m_bout, eb);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk({nm, "_zero"}, zero, ez);
`else
        if (ez) begin end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d_tab;
        logic [7:0] b_tab;
        int dcnt;
        #1 rst_n = 1'b0;
        #1 chk_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op("op0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("op807f", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);

        // start re-pulsed mid-RUN must be ignored
        wait_idle();
        a = 8'h11; b = 8'h22; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                a = 8'h99; b = 8'h11; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcnt++;
                chk("repulse_diff", diff, 8'hEF);
                chk("repulse_bout", bout, 1);
            end
            @(negedge clk);
        end
        chk("repulse_done_count", dcnt, 1);

        // start held high: one operation per W+2 cycles
        wait_idle();
        a = 8'hFF; b = 8'h01; bin = 1'b1; start = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("held_diff", diff, 8'hFD);
                chk("held_bout", bout, 0);
            end
        end
        start = 1'b0;
        chk("held_done_count", dcnt, 4);

        // reset mid-RUN
        wait_idle();
        a = 8'hF0; b = 8'h0F; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_bout", bout, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int sel;
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            b = (sel == 2) ? a : 8'($urandom);
            bin = 1'($urandom);
        end
        start = 1'b0;
        wait_idle();

        // WIDTH=1 full-subtractor truth table
        d_tab = 8'b10010110;
        b_tab = 8'b10001110;
        for (int i = 0; i < 8; i++) begin
            int lat;
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            chk("w1_busy", busy1, 1);
            lat = 0;
            while (!done1 && lat < 5) begin
                @(negedge clk);
                lat++;
            end
            chk("w1_latency", lat, 1);
            chk("w1_diff", diff1, d_tab[i]);
            chk("w1_bout", bout1, b_tab[i]);
            @(negedge clk);
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
